// File: rtl/rsa_pkg.sv
// Shared constants and state encoding for the RSA secondary-input stage.
package rsa_pkg;

    localparam int unsigned DATA_LENGTH = 1024;
    localparam int unsigned DATA_WIDTH  = 32;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

endpackage

// File: rtl/mod_double.sv
// Combinational modular doubling: y = 2x mod m, valid when x < m.
module mod_double
    import rsa_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_LENGTH
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH:0] d;
    logic [WIDTH:0] diff;

    always_comb begin
        d    = {x, 1'b0};
        diff = d - {1'b0, m};
        y    = (d >= {1'b0, m}) ? diff[WIDTH-1:0] : d[WIDTH-1:0];
    end

endmodule

// File: rtl/constant_r_t_new.sv
// Bit-serial computation of the Montgomery constants 2^WIDTH mod M_r and
// 2^(2*WIDTH) mod M_r, one modular doubling per clock.
module constant_r_t_new
    import rsa_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_LENGTH,
    parameter int unsigned CNT_W = $clog2(2 * WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] M_r,
    output logic [WIDTH-1:0] R_r,
    output logic [WIDTH-1:0] R_t,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] r_r_q, r_r_d;
    logic [WIDTH-1:0] r_t_q, r_t_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] x_nxt;
    logic             degenerate;

    mod_double #(
        .WIDTH(WIDTH)
    ) u_mod_double (
        .x(x_q),
        .m(M_r),
        .y(x_nxt)
    );

    // x starts at 1, which is not reduced for M_r <= 1; the true result there is 0.
    assign degenerate = (M_r[WIDTH-1:1] == '0);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        r_r_d   = r_r_q;
        r_t_d   = r_t_q;
        done_d  = 1'b0;
        if (start) begin
            state_d = RUN;
            x_d     = WIDTH'(1);
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            x_d   = x_nxt;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                r_r_d = degenerate ? '0 : x_nxt;
            end
            if (cnt_q == CNT_W'(2 * WIDTH - 1)) begin
                r_t_d   = degenerate ? '0 : x_nxt;
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            cnt_q   <= '0;
            r_r_q   <= '0;
            r_t_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            r_r_q   <= r_r_d;
            r_t_q   <= r_t_d;
            done_q  <= done_d;
        end
    end

    assign R_r  = r_r_q;
    assign R_t  = r_t_q;
    assign done = done_q;

endmodule

// File: tb/tb_constant_r_t_new.sv
// Scoreboard bench: stimulus queues expected results, monitors check each done pulse.
module tb_constant_r_t_new;

    localparam int unsigned W   = 1024;
    localparam int unsigned W16 = 16;

    typedef struct {
        logic [W-1:0] r;
        logic [W-1:0] t;
        int unsigned  cyc;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   M_r;
    logic [W-1:0]   R_r;
    logic [W-1:0]   R_t;
    logic           done;
    logic           start16;
    logic [W16-1:0] m16;
    logic [W16-1:0] rr16;
    logic [W16-1:0] rt16;
    logic           done16;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cyc    = 0;
    exp_t        q[$];
    exp_t        q16[$];

    constant_r_t_new #(
        .WIDTH(W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .M_r  (M_r),
        .R_r  (R_r),
        .R_t  (R_t),
        .done (done)
    );

    constant_r_t_new #(
        .WIDTH(W16)
    ) dut16 (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start16),
        .M_r  (m16),
        .R_r  (rr16),
        .R_t  (rt16),
        .done (done16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got(low128)=%h want(low128)=%h", name, got[127:0], want[127:0]);
        end
    endtask

    // Main-DUT monitor.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done cyc=%0d got=1 want=0", cyc);
            end else begin
                e = q.pop_front();
                checks++;
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL done_latency got=%0d want=%0d", cyc, e.cyc);
                end
                check_val("R_r", R_r, e.r);
                check_val("R_t", R_t, e.t);
            end
        end
    end

    // 16-bit DUT monitor.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done16) begin
            if (q16.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done16 cyc=%0d got=1 want=0", cyc);
            end else begin
                e = q16.pop_front();
                checks++;
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL done16_latency got=%0d want=%0d", cyc, e.cyc);
                end
                check_val("R_r16", {{(W-W16){1'b0}}, rr16}, e.r);
                check_val("R_t16", {{(W-W16){1'b0}}, rt16}, e.t);
            end
        end
    end

    task automatic pulse_start(input logic [W-1:0] m, input logic [W-1:0] er,
                               input logic [W-1:0] et, input bit expect_done);
        exp_t e;
        @(negedge clk);
        M_r   = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (expect_done) begin
            e.r   = er;
            e.t   = et;
            e.cyc = cyc + 2 * W;
            q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while ((q.size() != 0 || q16.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (q.size() != 0 || q16.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout pending=%0d want=0", q.size() + q16.size());
            q.delete();
            q16.delete();
        end
    endtask

    task automatic run_and_hold(input logic [W-1:0] m, input logic [W-1:0] er,
                                input logic [W-1:0] et);
        pulse_start(m, er, et, 1'b1);
        wait_drain(2 * W + 50);
        repeat (20) @(negedge clk);
        check_val("R_r_hold", R_r, er);
        check_val("R_t_hold", R_t, et);
    endtask

    initial begin
        logic [W-1:0] m_a;
        logic [W-1:0] m_all;
        exp_t         e;

        rst_n   = 1'b0;
        start   = 1'b0;
        start16 = 1'b0;
        M_r     = '0;
        m16     = '0;

        // Reset held across a start pulse.
        repeat (2) @(negedge clk);
        start = 1'b1;
        M_r   = W'(7);
        repeat (3) @(negedge clk);
        check_val("rst_R_r", R_r, '0);
        check_val("rst_R_t", R_t, '0);
        check_val("rst_done", {{(W-1){1'b0}}, done}, '0);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3000) @(negedge clk);
        check_val("idle_R_r", R_r, '0);
        check_val("idle_R_t", R_t, '0);

        m_a = (W'(1) << (W - 1)) + W'(1);
        run_and_hold(m_a, m_a - W'(2), W'(4));

        m_all = '1;
        run_and_hold(m_all, W'(1), W'(1));

        run_and_hold(W'(7), W'(2), W'(4));

        // Mid-run reset with M_r = 0: outputs clear, no done.
        pulse_start('0, '0, '0, 1'b0);
        repeat (1000) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("midrst_R_r", R_r, '0);
        check_val("midrst_R_t", R_t, '0);
        rst_n = 1'b1;
        repeat (2200) @(negedge clk);

        // 16-bit build.
        @(negedge clk);
        m16     = 16'hFFF1;
        start16 = 1'b1;
        @(posedge clk);
        #1;
        e.r   = W'(16'h000F);
        e.t   = W'(16'h00E1);
        e.cyc = cyc + 2 * W16;
        q16.push_back(e);
        @(negedge clk);
        start16 = 1'b0;
        wait_drain(2 * W16 + 20);

        // Restart mid-run: only the second start completes.
        pulse_start(W'(3), '0, '0, 1'b0);
        repeat (499) @(negedge clk);
        pulse_start(W'(3), W'(1), W'(1), 1'b1);
        wait_drain(2 * W + 50);

        run_and_hold('0, '0, '0);
        run_and_hold(W'(1), '0, '0);

        repeat (10) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
